ra_2r1w_sdr_gen: RTL and testbench
==================================

// Module: ra_2r1w_sdr_gen
// PURPOSE
//  Parametrised 2-read/1-write SDR register-file wrapper; next generation of the 64x72 wrapper.
//  Tiles regfile_2r1w_64x24 hard macros: WIDTH/24 slices across, 2**(AW-6) banks deep.
//  Adds per-slice write select, read-after-write bypass, read-valid outputs and a post-reset zero-init sequencer.
//  Sits between core pipeline logic and the hard arrays; address predecode comes from address_clock_sdr_2r1w_64, one per bank.
// PARAMETERS
//  GENMODE        `GENMODE  0=no delay (strobe forced 1), 1=delay mode (strobe used)
//  LATCHRD        1         1=register read data/valid (2-cycle latency), 0=unlatched (1-cycle)
//  WIDTH          72        data width; multiple of 24, min 24
//  AW             6         address width; depth=2**AW, min 6; banks NB=2**(AW-6)
//  BYPASS         1         1=forward write data to same-address read in same array cycle
//  INIT_ON_RESET  1         1=zero entire array after reset
// PORTS
//  clk        in   1         clock
//  reset      in   1         synchronous, active-high reset
//  strobe     in   1         array strobe (ignored when GENMODE=0)
//  init_busy  out  1         init sequence in progress; all requests ignored
//  rd_enb_0   in   1         read port 0 enable
//  rd_adr_0   in   [0:AW-1]  read port 0 address
//  rd_val_0   out  1         rd_dat_0 valid
//  rd_dat_0   out  [0:WIDTH-1] read port 0 data
//  rd_enb_1   in   1         read port 1 enable
//  rd_adr_1   in   [0:AW-1]  read port 1 address
//  rd_val_1   out  1         rd_dat_1 valid
//  rd_dat_1   out  [0:WIDTH-1] read port 1 data
//  wr_enb_0   in   1         write enable
//  wr_sel_0   in   [0:WIDTH/24-1] per-24b-slice write select (bit 0 = dat[0:23])
//  wr_adr_0   in   [0:AW-1]  write address
//  wr_dat_0   in   [0:WIDTH-1] write data
// BEHAVIOUR
//  - Cycle 0: inputs sampled into _q regs (reset to 0). Cycle 1: array accessed from _q; write lands end of cycle 1.
//  - LATCHRD=0: rd_dat/rd_val valid in cycle 1 (combinational from array). LATCHRD=1: registered, valid cycle 2.
//  - rd_val_n = rd_enb_n_q & ~init_busy, delayed per LATCHRD. rd_dat is don't-care when rd_val=0.
//  - Reset values: init_busy=INIT_ON_RESET, rd_val_*=0, rd_dat_*=0 (LATCHRD=1), all _q regs 0.
//  - Banking: adr[0:AW-7] selects bank; write enable gated to selected bank only; read mux by latched bank bits.
//  - Slice write: only slices with wr_sel_0_q=1 written; wr_enb_0 with wr_sel_0=0 is a no-op.
//  - Bypass (BYPASS=1): wr_enb_0_q & rd_enb_n_q & wr_adr_0_q==rd_adr_n_q -> selected slices from wr_dat_0_q,
//    unselected slices from array. Applies to both read ports independently/simultaneously.
//    BYPASS=0: same-address read/write returns undefined data; rd_val still asserted.
//  - Init FSM states IDLE, INIT; counter cnt[AW-1:0]:
//    reset high -> INIT (if INIT_ON_RESET) else IDLE, cnt=0, no array writes while reset high.
//    INIT: each cycle write all slices of entry cnt with 0; cnt++; at cnt=2**AW-1 write then -> IDLE.
//    init_busy=1 in INIT: exactly 2**AW cycles after reset deasserts. Reset mid-INIT restarts cnt=0.
//    User rd/wr enables ignored in INIT (not queued); first accepted request is cycle init_busy=0.
//  - Address wrap: none needed (power-of-2 depth); cnt wraps only at INIT exit.
//  - strobe_int = 1 when GENMODE=0 else strobe; fed to every bank's address/clock block.
// TESTING
//  1 Reset 1 cyc, INIT_ON_RESET=1, AW=6 -> init_busy high 64 cyc; then read all 64 addr -> all 0, rd_val=1.
//  2 Write adr 5 = 72'hA5..A5 sel=111, read port0 adr5 next cycle -> A5..A5 at LATCHRD latency (2 cyc).
//  3 Same-cycle wr adr 9 sel=010 dat=all-1, rd0+rd1 adr 9 (old all-0) -> both return 0x000000_FFFFFF_000000 (BYPASS=1).
//  4 AW=7: write adr 0x05=X, 0x45=Y; read both -> X,Y; bank isolation holds.
//  5 Assert reset at cnt=30 of INIT -> init_busy stays high 64 more cycles post-deassert; rd_enb during INIT -> rd_val=0.
//  6 LATCHRD=0, WIDTH=48: rd_enb cycle 0 -> rd_val_0=1 and data valid in cycle 1, rd_val=0 cycle 2 if enb dropped.

Source files
------------

// File: rtl/ra_2r1w_sdr_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ra_2r1w_sdr_gen_if                                                         |
// | Request/response bundle for the 2-read/1-write SDR register-file wrapper. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ra_2r1w_sdr_gen_if #(
  parameter int WIDTH = 72,
  parameter int AW    = 6
);
  logic                  strobe;
  logic                  init_busy;
  logic                  rd_enb_0;
  logic [0:AW-1]         rd_adr_0;
  logic                  rd_val_0;
  logic [0:WIDTH-1]      rd_dat_0;
  logic                  rd_enb_1;
  logic [0:AW-1]         rd_adr_1;
  logic                  rd_val_1;
  logic [0:WIDTH-1]      rd_dat_1;
  logic                  wr_enb_0;
  logic [0:WIDTH/24-1]   wr_sel_0;
  logic [0:AW-1]         wr_adr_0;
  logic [0:WIDTH-1]      wr_dat_0;

  modport master (
    output strobe, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1,
           wr_enb_0, wr_sel_0, wr_adr_0, wr_dat_0,
    input  init_busy, rd_val_0, rd_dat_0, rd_val_1, rd_dat_1
  );

  modport slave (
    input  strobe, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1,
           wr_enb_0, wr_sel_0, wr_adr_0, wr_dat_0,
    output init_busy, rd_val_0, rd_dat_0, rd_val_1, rd_dat_1
  );
endinterface
`default_nettype wire

// File: rtl/ra_2r1w_sdr_gen.sv
`default_nettype none
`ifndef GENMODE
`define GENMODE 0
`endif
// +----------------------------------------------------------------------------+
// | ra_2r1w_sdr_gen                                                            |
// | Banked/sliced 2R1W register file with slice write select, read-after-     |
// | write bypass, read-valid outputs and post-reset zero-init sequencer.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ra_2r1w_sdr_gen #(
  parameter int GENMODE       = `GENMODE,
  parameter int LATCHRD       = 1,
  parameter int WIDTH         = 72,
  parameter int AW            = 6,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  ra_2r1w_sdr_gen_if.slave bus
);
  localparam int            c_slices   = WIDTH / 24;
  localparam int            c_banks    = 2 ** (AW - 6);
  localparam logic [AW-1:0] c_cnt_last = '1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_INIT = 1'b1} state_t;

  state_t              r_state;
  logic                r_init_busy;
  logic [AW-1:0]       r_cnt;

  logic                r_rd_enb_0, r_rd_enb_1, r_wr_enb;
  logic [AW-1:0]       r_rd_adr_0, r_rd_adr_1, r_wr_adr;
  logic [0:c_slices-1] r_wr_sel;
  logic [0:WIDTH-1]    r_wr_dat;

  logic                w_strobe, w_user_wr, w_init_wr, w_arr_we;
  logic [AW-1:0]       w_arr_adr;
  logic [0:c_slices-1] w_arr_sel;
  logic [0:WIDTH-1]    w_arr_dat;
  logic [c_banks-1:0]  w_bank_we;
  logic [c_banks-1:0][0:WIDTH-1] w_bank_rd_0, w_bank_rd_1;
  logic [0:WIDTH-1]    w_rd_raw_0, w_rd_raw_1, w_rd_dat_0, w_rd_dat_1;
  logic                w_byp_0, w_byp_1, w_rd_val_0, w_rd_val_1;

  // Requests presented while init is running are dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_enb_0 <= 1'b0;
      r_rd_enb_1 <= 1'b0;
      r_wr_enb   <= 1'b0;
      r_rd_adr_0 <= '0;
      r_rd_adr_1 <= '0;
      r_wr_adr   <= '0;
      r_wr_sel   <= '0;
      r_wr_dat   <= '0;
    end else begin
      r_rd_enb_0 <= bus.rd_enb_0 & ~r_init_busy;
      r_rd_enb_1 <= bus.rd_enb_1 & ~r_init_busy;
      r_wr_enb   <= bus.wr_enb_0 & ~r_init_busy;
      r_rd_adr_0 <= bus.rd_adr_0;
      r_rd_adr_1 <= bus.rd_adr_1;
      r_wr_adr   <= bus.wr_adr_0;
      r_wr_sel   <= bus.wr_sel_0;
      r_wr_dat   <= bus.wr_dat_0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      r_init_busy <= (INIT_ON_RESET != 0);
      r_cnt       <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_cnt_last) begin
        r_state     <= ST_IDLE;
        r_init_busy <= 1'b0;
      end
    end
  end

  assign w_strobe  = (GENMODE == 0) ? 1'b1 : bus.strobe;
  assign w_user_wr = r_wr_enb & ~r_init_busy & w_strobe & ~reset;
  assign w_init_wr = (r_state == ST_INIT) & ~reset;
  assign w_arr_we  = w_init_wr | w_user_wr;
  assign w_arr_adr = w_init_wr ? r_cnt : r_wr_adr;
  assign w_arr_sel = w_init_wr ? '1 : r_wr_sel;
  assign w_arr_dat = w_init_wr ? '0 : r_wr_dat;

  for (genvar b = 0; b < c_banks; b++) begin : g_bank
    for (genvar s = 0; s < c_slices; s++) begin : g_slice
      logic [0:23] r_mem [64];

      always_ff @(posedge clk) begin
        if (w_bank_we[b] && w_arr_sel[s])
          r_mem[w_arr_adr[5:0]] <= w_arr_dat[s*24 +: 24];
      end

      assign w_bank_rd_0[b][s*24 +: 24] = r_mem[r_rd_adr_0[5:0]];
      assign w_bank_rd_1[b][s*24 +: 24] = r_mem[r_rd_adr_1[5:0]];
    end
  end

  // Upper address bits pick the bank; a single bank needs no decode.
  if (c_banks == 1) begin : g_one_bank
    assign w_bank_we  = w_arr_we;
    assign w_rd_raw_0 = w_bank_rd_0[0];
    assign w_rd_raw_1 = w_bank_rd_1[0];
  end else begin : g_multi_bank
    for (genvar b = 0; b < c_banks; b++) begin : g_we
      assign w_bank_we[b] = w_arr_we && (w_arr_adr[AW-1:6] == (AW-6)'(b));
    end
    assign w_rd_raw_0 = w_bank_rd_0[r_rd_adr_0[AW-1:6]];
    assign w_rd_raw_1 = w_bank_rd_1[r_rd_adr_1[AW-1:6]];
  end

  assign w_byp_0 = (BYPASS != 0) && w_user_wr && r_rd_enb_0 && (r_wr_adr == r_rd_adr_0);
  assign w_byp_1 = (BYPASS != 0) && w_user_wr && r_rd_enb_1 && (r_wr_adr == r_rd_adr_1);

  always_comb begin
    w_rd_dat_0 = w_rd_raw_0;
    w_rd_dat_1 = w_rd_raw_1;
    for (int s = 0; s < c_slices; s++) begin
      if (w_byp_0 && r_wr_sel[s]) w_rd_dat_0[s*24 +: 24] = r_wr_dat[s*24 +: 24];
      if (w_byp_1 && r_wr_sel[s]) w_rd_dat_1[s*24 +: 24] = r_wr_dat[s*24 +: 24];
    end
  end

  assign w_rd_val_0 = r_rd_enb_0 & ~r_init_busy;
  assign w_rd_val_1 = r_rd_enb_1 & ~r_init_busy;

  if (LATCHRD != 0) begin : g_latch
    logic             r_val_0, r_val_1;
    logic [0:WIDTH-1] r_dat_0, r_dat_1;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_val_0 <= 1'b0;
        r_val_1 <= 1'b0;
        r_dat_0 <= '0;
        r_dat_1 <= '0;
      end else begin
        r_val_0 <= w_rd_val_0;
        r_val_1 <= w_rd_val_1;
        r_dat_0 <= w_rd_dat_0;
        r_dat_1 <= w_rd_dat_1;
      end
    end

    assign bus.rd_val_0 = r_val_0;
    assign bus.rd_val_1 = r_val_1;
    assign bus.rd_dat_0 = r_dat_0;
    assign bus.rd_dat_1 = r_dat_1;
  end else begin : g_comb
    assign bus.rd_val_0 = w_rd_val_0;
    assign bus.rd_val_1 = w_rd_val_1;
    assign bus.rd_dat_0 = w_rd_dat_0;
    assign bus.rd_dat_1 = w_rd_dat_1;
  end

  assign bus.init_busy = r_init_busy;
endmodule
`default_nettype wire

// File: tb/tb_ra_2r1w_sdr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ra_2r1w_sdr_gen                                                         |
// | Two instances (72b/AW7/latched, 48b/AW6/unlatched) against a memory model.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ra_2r1w_sdr_gen;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ra_2r1w_sdr_gen_if #(.WIDTH(72), .AW(7)) a_if ();
  ra_2r1w_sdr_gen_if #(.WIDTH(48), .AW(6)) b_if ();

  ra_2r1w_sdr_gen #(.GENMODE(0), .LATCHRD(1), .WIDTH(72), .AW(7), .BYPASS(1), .INIT_ON_RESET(1))
    u_dut_a (.clk(clk), .reset(reset), .bus(a_if));
  ra_2r1w_sdr_gen #(.GENMODE(0), .LATCHRD(0), .WIDTH(48), .AW(6), .BYPASS(1), .INIT_ON_RESET(1))
    u_dut_b (.clk(clk), .reset(reset), .bus(b_if));

  typedef struct {
    logic [71:0] d;
    int          c;
  } exp_t;

  exp_t        qa0[$], qa1[$], qb0[$], qb1[$];
  logic [71:0] mem_a [128];
  logic [71:0] mem_b [64];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s valid with nothing outstanding at cycle %0d", nm, cyc);
  endtask

  task automatic chk_rd(input string nm, input logic [71:0] act, input exp_t e);
    chk({nm, "_dat"}, act, e.d);
    chk({nm, "_cyc"}, 72'(cyc), 72'(e.c));
  endtask

  // A slice is 24 bits; sel bit k covers data bits [k*24 +: 24] numerically.
  function automatic logic [71:0] merge(input logic [71:0] old, input logic [71:0] nw,
                                        input logic [2:0] sel);
    logic [71:0] r = old;
    for (int k = 0; k < 3; k++) if (sel[k]) r[k*24 +: 24] = nw[k*24 +: 24];
    return r;
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  function automatic logic [6:0] rnd_adr();
    if ($urandom_range(0, 3) == 0) return 7'($urandom());
    return 7'($urandom_range(0, 1) * 64 + $urandom_range(0, 3));
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 128; i++) mem_a[i] = '0;
    for (int i = 0; i < 64; i++) mem_b[i] = '0;
  endtask

  // Called #1 after a rising edge; the values driven here are sampled at the next edge.
  task automatic issue(input bit r0e, input logic [6:0] r0a, input bit r1e, input logic [6:0] r1a,
                       input bit we, input logic [2:0] sel, input logic [6:0] wa,
                       input logic [71:0] wd);
    exp_t        e;
    logic [71:0] wdb;
    logic [2:0]  selb;
    a_if.rd_enb_0 = r0e;  a_if.rd_adr_0 = r0a;
    a_if.rd_enb_1 = r1e;  a_if.rd_adr_1 = r1a;
    a_if.wr_enb_0 = we;   a_if.wr_sel_0 = sel;      a_if.wr_adr_0 = wa;       a_if.wr_dat_0 = wd;
    b_if.rd_enb_0 = r0e;  b_if.rd_adr_0 = r0a[5:0];
    b_if.rd_enb_1 = r1e;  b_if.rd_adr_1 = r1a[5:0];
    b_if.wr_enb_0 = we;   b_if.wr_sel_0 = sel[2:1]; b_if.wr_adr_0 = wa[5:0];  b_if.wr_dat_0 = wd[71:24];
    if (!reset && !a_if.init_busy) begin
      e.c = cyc + 2;
      if (r0e) begin
        e.d = (we && wa == r0a) ? merge(mem_a[r0a], wd, sel) : mem_a[r0a];
        qa0.push_back(e);
      end
      if (r1e) begin
        e.d = (we && wa == r1a) ? merge(mem_a[r1a], wd, sel) : mem_a[r1a];
        qa1.push_back(e);
      end
      if (we) mem_a[wa] = merge(mem_a[wa], wd, sel);
    end
    if (!reset && !b_if.init_busy) begin
      wdb  = {24'b0, wd[71:24]};
      selb = {1'b0, sel[2:1]};
      e.c  = cyc + 1;
      if (r0e) begin
        e.d = (we && wa[5:0] == r0a[5:0]) ? merge(mem_b[r0a[5:0]], wdb, selb) : mem_b[r0a[5:0]];
        qb0.push_back(e);
      end
      if (r1e) begin
        e.d = (we && wa[5:0] == r1a[5:0]) ? merge(mem_b[r1a[5:0]], wdb, selb) : mem_b[r1a[5:0]];
        qb1.push_back(e);
      end
      if (we) mem_b[wa[5:0]] = merge(mem_b[wa[5:0]], wdb, selb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(0, '0, 0, '0, 0, '0, '0, '0);
  endtask

  task automatic rnd_issue(input int pct);
    issue($urandom_range(0, 99) < pct, rnd_adr(), $urandom_range(0, 99) < pct, rnd_adr(),
          $urandom_range(0, 99) < pct, 3'($urandom()), rnd_adr(), rnd72());
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_a_busy"}, 72'(a_if.init_busy), 72'(1));
    chk({nm, "_a_val0"}, 72'(a_if.rd_val_0), 72'(0));
    chk({nm, "_a_val1"}, 72'(a_if.rd_val_1), 72'(0));
    chk({nm, "_a_dat0"}, a_if.rd_dat_0, 72'(0));
    chk({nm, "_a_dat1"}, a_if.rd_dat_1, 72'(0));
    chk({nm, "_b_busy"}, 72'(b_if.init_busy), 72'(1));
    chk({nm, "_b_val0"}, 72'(b_if.rd_val_0), 72'(0));
    chk({nm, "_b_val1"}, 72'(b_if.rd_val_1), 72'(0));
  endtask

  // Counts busy cycles on each instance while hammering both with ignored requests.
  task automatic count_init(input string nm);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_if.init_busy && !b_if.init_busy) break;
      na += int'(a_if.init_busy);
      nb += int'(b_if.init_busy);
      rnd_issue(90);
    end
    chk({nm, "_a_init_cycles"}, 72'(na), 72'(128));
    chk({nm, "_b_init_cycles"}, 72'(nb), 72'(64));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (a_if.rd_val_0) begin
        if (qa0.size() == 0) unexpected("a_rd0");
        else begin e = qa0.pop_front(); chk_rd("a_rd0", a_if.rd_dat_0, e); end
      end
      if (a_if.rd_val_1) begin
        if (qa1.size() == 0) unexpected("a_rd1");
        else begin e = qa1.pop_front(); chk_rd("a_rd1", a_if.rd_dat_1, e); end
      end
      if (b_if.rd_val_0) begin
        if (qb0.size() == 0) unexpected("b_rd0");
        else begin e = qb0.pop_front(); chk_rd("b_rd0", {24'b0, b_if.rd_dat_0}, e); end
      end
      if (b_if.rd_val_1) begin
        if (qb1.size() == 0) unexpected("b_rd1");
        else begin e = qb1.pop_front(); chk_rd("b_rd1", {24'b0, b_if.rd_dat_1}, e); end
      end
    end
  end

  initial begin
    a_if.strobe = 1'b1;
    b_if.strobe = 1'b1;
    a_if.rd_enb_0 = 0; a_if.rd_enb_1 = 0; a_if.wr_enb_0 = 0;
    a_if.rd_adr_0 = '0; a_if.rd_adr_1 = '0; a_if.wr_adr_0 = '0; a_if.wr_sel_0 = '0; a_if.wr_dat_0 = '0;
    b_if.rd_enb_0 = 0; b_if.rd_enb_1 = 0; b_if.wr_enb_0 = 0;
    b_if.rd_adr_0 = '0; b_if.rd_adr_1 = '0; b_if.wr_adr_0 = '0; b_if.wr_sel_0 = '0; b_if.wr_dat_0 = '0;
    zero_models();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    reset = 1'b0;
    count_init("por");

    // Whole-array sweep on both ports: everything reads back zero.
    for (int i = 0; i < 128; i++) issue(1, 7'(i), 1, 7'(127 - i), 0, '0, '0, '0);

    // Full write then read of the next cycle.
    issue(0, '0, 0, '0, 1, 3'b111, 7'd5, {9{8'hA5}});
    issue(1, 7'd5, 0, '0, 0, '0, '0, '0);

    // Same-cycle middle-slice write with both ports reading the same entry.
    issue(1, 7'd9, 1, 7'd9, 1, 3'b010, 7'd9, '1);
    issue(1, 7'd9, 1, 7'd9, 0, '0, '0, '0);

    // Bank isolation: entries 0x05 and 0x45 share an in-bank index.
    issue(0, '0, 0, '0, 1, 3'b111, 7'h05, 72'h111111_222222_333333);
    issue(0, '0, 0, '0, 1, 3'b111, 7'h45, 72'h444444_555555_666666);
    issue(1, 7'h05, 1, 7'h45, 0, '0, '0, '0);
    issue(0, '0, 0, '0, 0, '0, '0, '0);

    // A write with no slice selected leaves the entry untouched.
    issue(0, '0, 0, '0, 1, 3'b000, 7'h05, '1);
    issue(1, 7'h05, 1, 7'h05, 0, '0, '0, '0);

    for (int i = 0; i < 800; i++) rnd_issue(60);
    for (int i = 0; i < 200; i++) rnd_issue(25);

    repeat (3) idle();
    reset = 1'b1;
    zero_models();
    idle();
    reset_checks("rst2");
    reset = 1'b0;
    repeat (30) rnd_issue(90);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    count_init("mid");

    for (int i = 0; i < 400; i++) rnd_issue(60);

    repeat (4) idle();
    chk("a_rd0_left", 72'(qa0.size()), 72'(0));
    chk("a_rd1_left", 72'(qa1.size()), 72'(0));
    chk("b_rd0_left", 72'(qb0.size()), 72'(0));
    chk("b_rd1_left", 72'(qb1.size()), 72'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
